// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin/fixed-priority arbiter feeding a single registered valid/ready output stage
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int MODE = 0,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);
  logic [SEL_W-1:0] ptr, gsel;
  logic [N-1:0] grant;
  logic [WIDTH-1:0] gdata;
  logic load, xfer;
  int base;
  assign base = (MODE == 1) ? 0 : int'(ptr);
  // first pass covers base..N-1, second pass wraps to the lowest index below base
  always_comb begin
    grant = '0;
    gsel = '0;
    gdata = '0;
    for (int i = 0; i < N; i++)
      if (in_valid[i] && i >= base && grant == '0) begin
        grant[i] = 1'b1;
        gsel = SEL_W'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    for (int i = 0; i < N; i++)
      if (in_valid[i] && grant == '0) begin
        grant[i] = 1'b1;
        gsel = SEL_W'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
  end
  assign load = ~out_valid | out_ready;
  assign xfer = load & (|in_valid);
  assign in_ready = grant & {N{load}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else begin
      out_valid <= xfer | (out_valid & ~out_ready);
      if (xfer) begin
        out_data <= gdata;
        out_sel <= gsel;
      end
      if (xfer && MODE == 0) ptr <= (gsel == SEL_W'(N - 1)) ? '0 : gsel + SEL_W'(1);
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: scoreboard bench for round-robin, fixed-priority and single-channel configurations
module tb_rr_arb_mux;
  logic clk, rst_n;
  logic [3:0] a_in_valid, a_in_ready, b_in_valid, b_in_ready;
  logic [127:0] a_in_data, b_in_data;
  logic a_out_valid, a_out_ready, b_out_valid, b_out_ready;
  logic [31:0] a_out_data, b_out_data;
  logic [1:0] a_out_sel, b_out_sel;
  logic [0:0] c_in_valid, c_in_ready, c_out_sel;
  logic [31:0] c_in_data, c_out_data;
  logic c_out_valid, c_out_ready;
  logic [33:0] qa[$], qb[$], qc[$];
  int n_cmp = 0, n_fail = 0;

  rr_arb_mux #(.WIDTH(32), .N(4), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_sel(a_out_sel), .out_ready(a_out_ready));
  rr_arb_mux #(.WIDTH(32), .N(4), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_sel(b_out_sel), .out_ready(b_out_ready));
  rr_arb_mux #(.WIDTH(32), .N(1), .MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_sel(c_out_sel), .out_ready(c_out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] ea(input int ch);
    return {2'(ch), 32'(32'hA0 + ch)};
  endfunction

  function automatic logic [33:0] eb(input int ch);
    return {2'(ch), 32'(32'hB0 + ch)};
  endfunction

  // monitors pop one expected {sel,data} per output handshake
  always @(negedge clk)
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_out", {a_out_sel, a_out_data}, 0);
      else chk("a_out", {a_out_sel, a_out_data}, qa.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", {b_out_sel, b_out_data}, 0);
      else chk("b_out", {b_out_sel, b_out_data}, qb.pop_front());
    end
  always @(negedge clk)
    if (rst_n && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) chk("c_unexpected_out", {c_out_sel, c_out_data}, 0);
      else chk("c_out", {1'b0, c_out_sel, c_out_data}, qc.pop_front());
    end

  initial begin
    a_in_valid = '0; b_in_valid = '0; c_in_valid = '0;
    a_out_ready = 0; b_out_ready = 0; c_out_ready = 0;
    a_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b_in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    c_in_data = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    a_in_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_sel", a_out_sel, 0);
    chk("rst_in_ready", a_in_ready, 4'b0001);
    rst_n = 1'b1;
    a_out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      qa.push_back(ea(k % 4));
      tick();
    end
    a_in_valid = 4'b0011;
    #1 chk("skip_in_ready", a_in_ready, 4'b0001);
    qa.push_back(ea(0));
    tick();
    a_in_valid = 4'b0010;
    #1 chk("wrap_in_ready", a_in_ready, 4'b0010);
    qa.push_back(ea(1));
    tick();
    a_in_valid = 4'b1111;
    #1 chk("ptr2_in_ready", a_in_ready, 4'b0100);
    qa.push_back(ea(2));
    tick();
    a_in_valid = 4'b0000;
    tick();
    chk("idle_drain_valid", a_out_valid, 0);
    a_in_valid = 4'b0110;
    a_out_ready = 0;
    #1 chk("bp_first_ready", a_in_ready, 4'b0010);
    qa.push_back(ea(1));
    tick();
    a_in_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready", a_in_ready, 4'b0000);
      chk("bp_out_sel", a_out_sel, 1);
      chk("bp_out_data", a_out_data, 32'hA1);
      tick();
    end
    a_out_ready = 1;
    #1 chk("drain_load_ready", a_in_ready, 4'b0100);
    qa.push_back(ea(2));
    tick();
    chk("drain_load_sel", a_out_sel, 2);
    chk("drain_load_valid", a_out_valid, 1);
    a_in_valid = 4'b0000;
    tick();
    chk("drain_valid", a_out_valid, 0);
    a_in_valid = 4'b0100;
    a_out_ready = 0;
    tick();
    a_in_valid = 4'b0000;
    chk("pre_rst_valid", a_out_valid, 1);
    chk("pre_rst_sel", a_out_sel, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", a_out_valid, 0);
    chk("async_rst_data", a_out_data, 0);
    chk("async_rst_sel", a_out_sel, 0);
    tick();
    rst_n = 1'b1;
    a_in_valid = 4'b1111;
    a_out_ready = 1;
    #1 chk("post_rst_ready", a_in_ready, 4'b0001);
    qa.push_back(ea(0));
    tick();
    qa.push_back(ea(1));
    tick();
    a_in_valid = 4'b0000;
    repeat (2) tick();

    b_out_ready = 1;
    b_in_valid = 4'b1110;
    #1 chk("fp_in_ready", b_in_ready, 4'b0010);
    qb.push_back(eb(1));
    tick();
    b_in_valid = 4'b1100;
    qb.push_back(eb(2));
    tick();
    b_in_valid = 4'b1000;
    qb.push_back(eb(3));
    tick();
    b_in_valid = 4'b0000;
    tick();
    b_in_valid = 4'b1001;
    #1 chk("fp_low_first", b_in_ready, 4'b0001);
    qb.push_back(eb(0));
    tick();
    b_in_valid = 4'b1000;
    qb.push_back(eb(3));
    tick();
    b_in_valid = 4'b0000;
    repeat (2) tick();

    c_out_ready = 1;
    c_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c_in_data = 32'hD0 + 32'(k);
      qc.push_back({2'b00, 32'hD0 + 32'(k)});
      tick();
      chk("n1_latency_valid", c_out_valid, 1);
      chk("n1_out_sel", c_out_sel, 0);
    end
    c_in_valid = 1'b0;
    tick();
    chk("n1_idle_valid", c_out_valid, 0);
    tick();

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("c_queue_empty", qc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
